// File: rtl/cond_path_delay_line_if.sv
// Signal bundle for cond_path_delay_line: mode/data paths, config write port and
// status outputs. master = environment driving the block, slave = the block itself.
interface cond_path_delay_line_if #(
    parameter int NCH   = 2,
    parameter int NCOND = 5,
    parameter int CNTW  = 4,
    parameter int MODEW = 3,
    parameter int ADDRW = $clog2(NCH*(NCOND+1))
);
    // Handshake: cfg_we is a single-cycle write strobe qualifying cfg_addr and
    // cfg_wdata at the rising edge; there is no ready/backpressure, every strobe
    // is consumed in the cycle it is presented. din/mode are level-sampled each edge.
    logic [MODEW-1:0]          mode;
    logic [NCH-1:0]            din;
    logic [NCH-1:0]            dout;
    logic [NCH-1:0]            pending;
    logic [NCH-1:0]            state_dbg;
    logic                      cfg_we;
    logic [ADDRW-1:0]          cfg_addr;
    logic [MODEW+2*CNTW-1:0]   cfg_wdata;
    logic [7:0]                glitch_cnt;

    modport master (
        output mode, din, cfg_we, cfg_addr, cfg_wdata,
        input  dout, pending, state_dbg, glitch_cnt
    );

    modport slave (
        input  mode, din, cfg_we, cfg_addr, cfg_wdata,
        output dout, pending, state_dbg, glitch_cnt
    );
endinterface

// File: rtl/cond_path_delay_line.sv
// Cycle-based state-dependent path delay model: per-path inertial delay chosen from
// a programmable default/conditional table, with saturating glitch counting.
module cond_path_delay_line #(
    parameter int NCH      = 2,
    parameter int NCOND    = 5,
    parameter int CNTW     = 4,
    parameter int MODEW    = 3,
    parameter int DEF_RISE = 6,
    parameter int DEF_FALL = 9
) (
    input logic                   clk,
    input logic                   rst_n,
    cond_path_delay_line_if.slave bus
);
    localparam int NSLOT = NCOND + 1;
    localparam int CW    = $clog2(NCH + 1);

    typedef logic [CNTW-1:0] dly_t;
    typedef enum logic {S_IDLE, S_WAIT} path_state_e;

    // Delay table
    dly_t             def_rise [NCH];
    dly_t             def_fall [NCH];
    logic [MODEW-1:0] c_mask   [NCH][NCOND];
    dly_t             c_rise   [NCH][NCOND];
    dly_t             c_fall   [NCH][NCOND];

    logic [MODEW-1:0] wr_mask;
    dly_t             wr_rise;
    dly_t             wr_fall;

    assign wr_mask = bus.cfg_wdata[MODEW+2*CNTW-1 -: MODEW];
    assign wr_rise = bus.cfg_wdata[2*CNTW-1 -: CNTW];
    assign wr_fall = bus.cfg_wdata[CNTW-1:0];

    // Addresses past the last slot match no entry and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < NCH; ch++) begin
                def_rise[ch] <= dly_t'(DEF_RISE);
                def_fall[ch] <= dly_t'(DEF_FALL);
                for (int k = 0; k < NCOND; k++) begin
                    c_mask[ch][k] <= '0;
                    c_rise[ch][k] <= '0;
                    c_fall[ch][k] <= '0;
                end
            end
        end else if (bus.cfg_we) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (int'(bus.cfg_addr) == ch*NSLOT) begin
                    def_rise[ch] <= wr_rise;
                    def_fall[ch] <= wr_fall;
                end
                for (int k = 0; k < NCOND; k++) begin
                    if (int'(bus.cfg_addr) == ch*NSLOT + k + 1) begin
                        c_mask[ch][k] <= wr_mask;
                        c_rise[ch][k] <= wr_rise;
                        c_fall[ch][k] <= wr_fall;
                    end
                end
            end
        end
    end

    // Delay selection: min over enabled conditional entries, else default; 0 acts as 1.
    dly_t rise_sel [NCH];
    dly_t fall_sel [NCH];

    always_comb begin
        logic any_en;
        dly_t rmin;
        dly_t fmin;
        dly_t rraw;
        dly_t fraw;
        any_en = 1'b0;
        rmin   = '1;
        fmin   = '1;
        rraw   = '0;
        fraw   = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            rise_sel[ch] = '0;
            fall_sel[ch] = '0;
        end
        for (int ch = 0; ch < NCH; ch++) begin
            any_en = 1'b0;
            rmin   = '1;
            fmin   = '1;
            for (int k = 0; k < NCOND; k++) begin
                if ((bus.mode & c_mask[ch][k]) != '0) begin
                    any_en = 1'b1;
                    if (c_rise[ch][k] < rmin) rmin = c_rise[ch][k];
                    if (c_fall[ch][k] < fmin) fmin = c_fall[ch][k];
                end
            end
            rraw = any_en ? rmin : def_rise[ch];
            fraw = any_en ? fmin : def_fall[ch];
            rise_sel[ch] = (rraw == '0) ? dly_t'(1) : rraw;
            fall_sel[ch] = (fraw == '0) ? dly_t'(1) : fraw;
        end
    end

    // Path state machines
    path_state_e    state_q [NCH];
    path_state_e    state_d [NCH];
    dly_t           cnt_q   [NCH];
    dly_t           cnt_d   [NCH];
    logic [NCH-1:0] dout_q, dout_d;
    logic [NCH-1:0] pend_q, pend_d;
    logic [NCH-1:0] cancel;
    logic [7:0]     glitch_q, glitch_d;
    logic [CW-1:0]  n_cancel;
    logic [8+CW-1:0] gsum;

    always_comb begin
        dout_d   = dout_q;
        pend_d   = pend_q;
        cancel   = '0;
        n_cancel = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            case (state_q[ch])
                S_IDLE: begin
                    // Delay is latched here; later table/mode changes cannot reach it.
                    if (bus.din[ch] != dout_q[ch]) begin
                        state_d[ch] = S_WAIT;
                        cnt_d[ch]   = bus.din[ch] ? rise_sel[ch] : fall_sel[ch];
                        pend_d[ch]  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (bus.din[ch] == dout_q[ch]) begin
                        state_d[ch] = S_IDLE;
                        cnt_d[ch]   = '0;
                        pend_d[ch]  = 1'b0;
                        cancel[ch]  = 1'b1;
                    end else if (cnt_q[ch] == dly_t'(1)) begin
                        state_d[ch] = S_IDLE;
                        cnt_d[ch]   = '0;
                        pend_d[ch]  = 1'b0;
                        dout_d[ch]  = bus.din[ch];
                    end else begin
                        cnt_d[ch] = cnt_q[ch] - dly_t'(1);
                    end
                end
                default: begin
                    state_d[ch] = S_IDLE;
                    cnt_d[ch]   = '0;
                    pend_d[ch]  = 1'b0;
                end
            endcase
        end
        for (int ch = 0; ch < NCH; ch++) begin
            n_cancel = n_cancel + CW'(cancel[ch]);
        end
        gsum     = (8+CW)'(glitch_q) + (8+CW)'(n_cancel);
        glitch_d = (|gsum[8+CW-1:8]) ? 8'hff : gsum[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < NCH; ch++) begin
                state_q[ch] <= S_IDLE;
                cnt_q[ch]   <= '0;
            end
            dout_q   <= '0;
            pend_q   <= '0;
            glitch_q <= '0;
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
            end
            dout_q   <= dout_d;
            pend_q   <= pend_d;
            glitch_q <= glitch_d;
        end
    end

    always_comb begin
        bus.state_dbg = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            bus.state_dbg[ch] = (state_q[ch] == S_WAIT);
        end
    end

    assign bus.dout       = dout_q;
    assign bus.pending    = pend_q;
    assign bus.glitch_cnt = glitch_q;

endmodule
